// File: rtl/led_chaser_n.sv
// led_chaser_n -- LED pattern generator (chase / bounce / fill / blink).
//
// Parameters:
//   N_LEDS   number of LED outputs (1..32)
//   TICK_DIV clk cycles per pattern step (>= 2)
// Ports:
//   clk   rising-edge clock
//   rst   synchronous active-high reset
//   en    1 = run, 0 = freeze prescaler and pattern
//   mode  00 CHASE, 01 BOUNCE, 10 FILL, 11 BLINK
//   dir   0 = toward led[N_LEDS-1], 1 = toward led[0] (CHASE/FILL)
//   dim   brightness level (only with LED_CHASER_DIM_EN)
//   led   registered LED drive, 1 = on
//   step  registered one-cycle pulse, high in the cycle led shows a new step
// Optional feature: define LED_CHASER_DIM_EN to add a 4-bit PWM dimmer.
//
// Pipeline: tick (cycle T) -> pattern state updates at end of T ->
// led and step both update at end of T+1.
module led_chaser_n #(
  parameter int unsigned N_LEDS   = 4,
  parameter int unsigned TICK_DIV = 2500000
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              en,
  input  logic [1:0]        mode,
  input  logic              dir,
  input  logic [3:0]        dim,
  output logic [N_LEDS-1:0] led,
  output logic              step
);

  localparam int unsigned CW = $clog2(TICK_DIV);
  localparam int unsigned PW = (N_LEDS > 1) ? $clog2(N_LEDS) : 1;
  localparam int unsigned LW = $clog2(N_LEDS + 1);
  localparam logic [CW-1:0] CNT_MAX = CW'(TICK_DIV - 1);
  localparam logic [PW-1:0] POS_MAX = PW'(N_LEDS - 1);
  localparam logic [LW-1:0] LVL_MAX = LW'(N_LEDS);

  typedef enum logic [1:0] {
    MODE_CHASE  = 2'b00,
    MODE_BOUNCE = 2'b01,
    MODE_FILL   = 2'b10,
    MODE_BLINK  = 2'b11
  } mode_e;

  mode_e             mode_in;
  mode_e             mode_q, mode_d;
  logic [CW-1:0]     cnt_q, cnt_d;
  logic [PW-1:0]     pos_q, pos_d;
  logic [LW-1:0]     lvl_q, lvl_d;
  logic              bdir_q, bdir_d;
  logic              blink_q, blink_d;
  logic              dir_q, dir_d;
  logic              tick_q, tick_d;
  logic [N_LEDS-1:0] led_q, led_d;
  logic              step_q, step_d;
  logic              mode_chg;
  logic              tick;
  logic              gate;
  logic [N_LEDS-1:0] pat;

`ifdef LED_CHASER_DIM_EN
  logic [3:0] pwm_q, pwm_d;
  always_comb begin
    pwm_d = pwm_q + 4'd1;
    gate  = (pwm_q <= dim);
  end
`else
  logic unused_dim;
  assign unused_dim = ^dim;
  assign gate       = 1'b1;
`endif

  assign mode_in  = mode_e'(mode);
  assign mode_chg = (mode_in != mode_q);
  // A mode change wins over a coincident tick.
  assign tick     = en && !mode_chg && (cnt_q == CNT_MAX);

  // Next pattern state.
  always_comb begin
    cnt_d   = cnt_q;
    pos_d   = pos_q;
    lvl_d   = lvl_q;
    bdir_d  = bdir_q;
    blink_d = blink_q;
    dir_d   = dir_q;
    mode_d  = mode_in;
    if (mode_chg) begin
      cnt_d   = '0;
      pos_d   = '0;
      lvl_d   = '0;
      bdir_d  = 1'b0;
      blink_d = 1'b0;
      dir_d   = dir;
    end else if (en) begin
      cnt_d = tick ? '0 : cnt_q + CW'(1);
      if (tick) begin
        // dir is captured only on a tick so a change takes effect at the next step.
        dir_d = dir;
        unique case (mode_q)
          MODE_CHASE: begin
            if (dir) pos_d = (pos_q == '0) ? POS_MAX : pos_q - PW'(1);
            else     pos_d = (pos_q == POS_MAX) ? '0 : pos_q + PW'(1);
          end
          MODE_BOUNCE: begin
            if (N_LEDS == 1) begin
              pos_d = '0;
            end else if (!bdir_q) begin
              if (pos_q == POS_MAX) begin
                pos_d  = POS_MAX - PW'(1);
                bdir_d = 1'b1;
              end else begin
                pos_d = pos_q + PW'(1);
              end
            end else begin
              if (pos_q == '0) begin
                pos_d  = PW'(1);
                bdir_d = 1'b0;
              end else begin
                pos_d = pos_q - PW'(1);
              end
            end
          end
          MODE_FILL:  lvl_d = (lvl_q == LVL_MAX) ? '0 : lvl_q + LW'(1);
          MODE_BLINK: blink_d = ~blink_q;
          default:    ;
        endcase
      end
    end
  end

  // Pattern decoded from the current state registers.
  always_comb begin
    pat = '0;
    for (int unsigned i = 0; i < N_LEDS; i++) begin
      unique case (mode_q)
        MODE_CHASE, MODE_BOUNCE: pat[i] = (i == 32'(pos_q));
        MODE_FILL: pat[i] = dir_q ? (i >= N_LEDS - 32'(lvl_q)) : (i < 32'(lvl_q));
        MODE_BLINK: pat[i] = blink_q;
        default:    pat[i] = 1'b0;
      endcase
    end
  end

  always_comb begin
    led_d  = pat & {N_LEDS{gate}};
    tick_d = tick;
    step_d = tick_q;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q   <= '0;
      pos_q   <= '0;
      lvl_q   <= '0;
      bdir_q  <= 1'b0;
      blink_q <= 1'b0;
      // Track the inputs during reset so release is not seen as a mode change.
      mode_q  <= mode_in;
      dir_q   <= dir;
      tick_q  <= 1'b0;
      led_q   <= '0;
      step_q  <= 1'b0;
`ifdef LED_CHASER_DIM_EN
      pwm_q   <= '0;
`endif
    end else begin
      cnt_q   <= cnt_d;
      pos_q   <= pos_d;
      lvl_q   <= lvl_d;
      bdir_q  <= bdir_d;
      blink_q <= blink_d;
      mode_q  <= mode_d;
      dir_q   <= dir_d;
      tick_q  <= tick_d;
      led_q   <= led_d;
      step_q  <= step_d;
`ifdef LED_CHASER_DIM_EN
      pwm_q   <= pwm_d;
`endif
    end
  end

  assign led  = led_q;
  assign step = step_q;

endmodule

// File: tb/tb_led_chaser_n.sv
// tb_led_chaser_n -- directed, table-driven bench for led_chaser_n
// (N_LEDS=4, TICK_DIV=4, default build without the dimmer).
module tb_led_chaser_n;

  logic       clk = 1'b0;
  logic       rst;
  logic       en;
  logic [1:0] mode;
  logic       dir;
  logic [3:0] dim;
  logic [3:0] led;
  logic       step;

  int unsigned total = 0;
  int unsigned bad   = 0;

  always #5 clk = ~clk;

  led_chaser_n #(.N_LEDS(4), .TICK_DIV(4)) dut (
    .clk (clk),
    .rst (rst),
    .en  (en),
    .mode(mode),
    .dir (dir),
    .dim (dim),
    .led (led),
    .step(step)
  );

  // Inputs are held for n cycles; every one of those cycles must show led/step.
  typedef struct {
    logic        rst;
    logic        en;
    logic [1:0]  mode;
    logic        dir;
    int unsigned n;
    logic [3:0]  led;
    logic        step;
  } vec_t;

  vec_t vecs[$];

  function automatic void add(input logic r, input logic e, input logic [1:0] m,
                              input logic d, input int unsigned n,
                              input logic [3:0] l, input logic s);
    vec_t v;
    v.rst = r; v.en = e; v.mode = m; v.dir = d; v.n = n; v.led = l; v.step = s;
    vecs.push_back(v);
  endfunction

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", name, got, exp);
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst = 1'b1; en = 1'b0; mode = 2'b00; dir = 1'b0; dim = 4'd3;

    // CHASE dir=0
    add(1,1,0,0,1,4'b0000,0);
    add(0,1,0,0,4,4'b0001,0);
    add(0,1,0,0,1,4'b0010,1); add(0,1,0,0,3,4'b0010,0);
    add(0,1,0,0,1,4'b0100,1); add(0,1,0,0,3,4'b0100,0);
    add(0,1,0,0,1,4'b1000,1); add(0,1,0,0,3,4'b1000,0);
    add(0,1,0,0,1,4'b0001,1); add(0,1,0,0,3,4'b0001,0);
    // CHASE dir=1 wraps 0 -> N-1
    add(1,1,0,1,1,4'b0000,0);
    add(0,1,0,1,4,4'b0001,0);
    add(0,1,0,1,1,4'b1000,1); add(0,1,0,1,3,4'b1000,0);
    add(0,1,0,1,1,4'b0100,1);
    // BOUNCE with dir toggling
    add(1,1,1,0,1,4'b0000,0);
    add(0,1,1,0,4,4'b0001,0);
    add(0,1,1,0,1,4'b0010,1); add(0,1,1,1,3,4'b0010,0);
    add(0,1,1,1,1,4'b0100,1); add(0,1,1,0,3,4'b0100,0);
    add(0,1,1,0,1,4'b1000,1); add(0,1,1,1,3,4'b1000,0);
    add(0,1,1,1,1,4'b0100,1); add(0,1,1,0,3,4'b0100,0);
    add(0,1,1,0,1,4'b0010,1); add(0,1,1,1,3,4'b0010,0);
    add(0,1,1,1,1,4'b0001,1); add(0,1,1,0,3,4'b0001,0);
    add(0,1,1,0,1,4'b0010,1);
    // FILL dir=1 with a 10-cycle freeze
    add(1,1,2,1,1,4'b0000,0);
    add(0,1,2,1,4,4'b0000,0);
    add(0,1,2,1,1,4'b1000,1); add(0,1,2,1,3,4'b1000,0);
    add(0,1,2,1,1,4'b1100,1);
    add(0,0,2,1,10,4'b1100,0);
    add(0,1,2,1,3,4'b1100,0);
    add(0,1,2,1,1,4'b1110,1); add(0,1,2,1,3,4'b1110,0);
    add(0,1,2,1,1,4'b1111,1); add(0,1,2,1,3,4'b1111,0);
    add(0,1,2,1,1,4'b0000,1);
    // CHASE -> BLINK at pos=2
    add(1,1,0,0,1,4'b0000,0);
    add(0,1,0,0,4,4'b0001,0);
    add(0,1,0,0,1,4'b0010,1); add(0,1,0,0,3,4'b0010,0);
    add(0,1,0,0,1,4'b0100,1);
    add(0,1,3,0,1,4'b0100,0);
    add(0,1,3,0,4,4'b0000,0);
    add(0,1,3,0,1,4'b1111,1); add(0,1,3,0,3,4'b1111,0);
    add(0,1,3,0,1,4'b0000,1);
    // FILL dir=0, reset at lvl=3 on the cycle a tick is due
    add(1,1,2,0,1,4'b0000,0);
    add(0,1,2,0,4,4'b0000,0);
    add(0,1,2,0,1,4'b0001,1); add(0,1,2,0,3,4'b0001,0);
    add(0,1,2,0,1,4'b0011,1); add(0,1,2,0,3,4'b0011,0);
    add(0,1,2,0,1,4'b0111,1); add(0,1,2,0,2,4'b0111,0);
    add(1,1,2,0,1,4'b0000,0);
    add(0,1,2,0,4,4'b0000,0);
    add(0,1,2,0,1,4'b0001,1); add(0,1,2,0,3,4'b0001,0);
    // FILL dir change applies at next tick, lvl kept
    add(1,1,2,0,1,4'b0000,0);
    add(0,1,2,0,4,4'b0000,0);
    add(0,1,2,0,1,4'b0001,1); add(0,1,2,0,3,4'b0001,0);
    add(0,1,2,0,1,4'b0011,1);
    add(0,1,2,1,3,4'b0011,0);
    add(0,1,2,1,1,4'b1110,1);

    foreach (vecs[i]) begin
      rst = vecs[i].rst; en = vecs[i].en; mode = vecs[i].mode; dir = vecs[i].dir;
      for (int unsigned c = 0; c < vecs[i].n; c++) begin
        cyc();
        chk($sformatf("row%0d.c%0d led", i, c), 32'(led), 32'(vecs[i].led));
        chk($sformatf("row%0d.c%0d step", i, c), 32'(step), 32'(vecs[i].step));
      end
    end

    // Mode change in the tick cycle: no step, pattern restarts; dim has no effect.
    rst = 1'b1; en = 1'b1; mode = 2'b00; dir = 1'b0;
    cyc();
    chk("mc reset led", 32'(led), 32'h0);
    rst = 1'b0;
    cyc(); cyc(); cyc();                 // now in the tick cycle
    mode = 2'b01;
    for (int unsigned c = 0; c < 5; c++) begin
      dim = 4'($urandom_range(0, 15));
      cyc();
      chk($sformatf("mc c%0d led", c), 32'(led), 32'h1);
      chk($sformatf("mc c%0d step", c), 32'(step), 32'h0);
    end
    cyc();
    chk("mc first led", 32'(led), 32'h2);
    chk("mc first step", 32'(step), 32'h1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/led_chaser_n.md
LED_CHASER_N -- requirements
Module: led_chaser_n

Interface
REQ-001 SHALL have parameter N_LEDS, default 4: number of LED outputs, legal range 1..32.
REQ-002 SHALL have parameter TICK_DIV, default 2500000: clk cycles per pattern step, legal range >=2.
REQ-003 SHALL have port clk  input  1  single clock; all logic on its rising edge.
REQ-004 SHALL have port rst  input  1  reset; synchronous, active-high.
REQ-005 SHALL have port en  input  1  1 = run, 0 = freeze prescaler and pattern.
REQ-006 SHALL have port mode  input  2  00 CHASE, 01 BOUNCE, 10 FILL, 11 BLINK.
REQ-007 SHALL have port dir  input  1  0 = toward led[N_LEDS-1], 1 = toward led[0]; used in CHASE and FILL only.
REQ-008 SHALL have port dim  input  4  brightness level; used only with LED_CHASER_DIM_EN.
REQ-009 SHALL have port led  output  N_LEDS  registered LED drive, 1 = on.
REQ-010 SHALL have port step  output  1  registered one-cycle pulse per pattern step.

Function
REQ-011 SHALL count prescaler cnt 0..TICK_DIV-1 while en=1; tick is asserted in the cycle cnt==TICK_DIV-1, and cnt then wraps to 0.
REQ-012 SHALL hold cnt, pattern state and led unchanged while en=0, with no tick generated.
REQ-013 SHALL register step as tick, high for exactly one cycle, aligned with the led update for that tick.
REQ-014 SHALL keep pos (0..N_LEDS-1), lvl (0..N_LEDS) and bdir (0 = up) as pattern state; led SHALL reflect new state one cycle after the state register changes.
REQ-015 SHALL in CHASE drive led one-hot at pos; on tick pos+1 (dir=0) or pos-1 (dir=1), wrapping N_LEDS-1->0 and 0->N_LEDS-1.
REQ-016 SHALL in BOUNCE drive led one-hot at pos; on tick move by bdir; at pos N_LEDS-1 going up, go to N_LEDS-2 and set bdir=1; at pos 0 going down, go to 1 and clear bdir; with N_LEDS=1, pos stays 0.
REQ-017 SHALL in FILL light the lvl lowest LEDs (dir=0) or the lvl highest LEDs (dir=1); on tick lvl+1, with lvl N_LEDS wrapping to 0 (all off).
REQ-018 SHALL in BLINK drive all LEDs equal; on tick invert all LEDs; first tick after entry turns all on.
REQ-019 SHALL, on any change of mode (sampled each cycle), clear cnt, pos, lvl, bdir and the BLINK phase in that cycle; no tick is generated in that cycle.
REQ-020 SHALL apply a dir change at the next tick without resetting pos or lvl.
REQ-021 SHALL treat tick and mode change in the same cycle as a mode change only.

Reset
REQ-022 SHALL, while rst=1, force cnt=0, pos=0, lvl=0, bdir=0, BLINK phase off, led=0, step=0 and PWM counter=0, with priority over en and mode.
REQ-023 SHALL, in the first cycle after rst falls, drive led with the pattern for state 0 of the current mode (CHASE/BOUNCE: led[0] on; FILL/BLINK: all off).
REQ-024 SHALL abort any step in progress on reset assertion mid-operation; no step pulse is emitted for the aborted period.

Configuration
REQ-025 SHALL, with macro LED_CHASER_DIM_EN defined, run a free-running 4-bit PWM counter p and drive led = pattern AND (p <= dim); dim=15 gives full on, dim=0 gives 1/16 duty.
REQ-026 SHALL, without LED_CHASER_DIM_EN, ignore dim, omit the PWM counter, and drive led = pattern.

Verification (N_LEDS=4, TICK_DIV=4)
REQ-027 SHALL cover CHASE, dir=0, en=1 from reset: led 0001->0010->0100->1000->0001, changing every 4 cycles with a step pulse at each change.
REQ-028 SHALL cover BOUNCE: led 0001,0010,0100,1000,0100,0010,0001,0010 on consecutive ticks; dir toggling has no effect.
REQ-029 SHALL cover FILL, dir=1: led 0000,1000,1100,1110,1111,0000; and en=0 for 10 cycles mid-sequence freezes led and cnt, with no step pulses.
REQ-030 SHALL cover a mode switch CHASE->BLINK at pos=2: led=0000 next-but-one cycle, then 1111 after 4 cycles, then 0000.
REQ-031 SHALL cover rst=1 for one cycle mid-FILL at lvl=3: led=0000 and step=0 the next cycle, then restart at lvl 0 with the first step 4 cycles after release.
REQ-032 SHALL cover, with LED_CHASER_DIM_EN and CHASE at led[0]: dim=3 gives led[0] high 4 of every 16 cycles; dim=15 gives constant high; without the macro, dim=3 gives constant high.
